// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/source types and default limits for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} arb_state_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up-counter with clear priority and a saturation flag
module arb_sat_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] count;
    assign sat = count == W'(MAX);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !sat) count <= count + W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with data priority and a fetch starvation guard
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int N = 64,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [31:0]  if_rdata,
    output logic         if_done,
    input  logic         dm_rd,
    input  logic         dm_wr,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_done,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         err,
    output logic         stall
);
    arb_state_t state;
    arb_src_t src;
    logic [N-1:0] rdata;
    logic dm_any, gnt_d, gnt_i, in_gnt, starve_sat, timeout;
    assign dm_any = dm_rd | dm_wr;
    assign gnt_d = state == IDLE && dm_any && (!if_req || !starve_sat);
    assign gnt_i = state == IDLE && if_req && !gnt_d;
    assign in_gnt = state == GNT_I || state == GNT_D;
    assign if_rdata = rdata[31:0];
    assign dm_rdata = rdata;
    // held in reset, every output reads 0 regardless of the request inputs
    assign stall = reset && (if_req || dm_any) && !(if_done || dm_done);
    arb_sat_counter #(.MAX(STARVE_LIMIT)) u_starve (
        .clk(clk), .reset(reset),
        .inc(gnt_d && if_req),
        .clr(gnt_i || (state == IDLE && !if_req)),
        .sat(starve_sat)
    );
    arb_sat_counter #(.MAX(TIMEOUT - 1)) u_timer (
        .clk(clk), .reset(reset),
        .inc(in_gnt),
        .clr(!in_gnt),
        .sat(timeout)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src       <= SRC_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_d || gnt_i) begin
                    state     <= gnt_d ? GNT_D : GNT_I;
                    src       <= gnt_d ? SRC_D : SRC_I;
                    mem_req   <= 1'b1;
                    mem_we    <= gnt_d && dm_wr;
                    mem_addr  <= gnt_d ? dm_addr : if_addr;
                    mem_wdata <= (gnt_d && dm_wr) ? dm_wdata : '0;
                end
                GNT_I, GNT_D: if (mem_ready || timeout) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    rdata     <= mem_ready ? mem_rdata : '0;
                    err       <= !mem_ready;
                    if_done   <= src == SRC_I;
                    dm_done   <= src == SRC_D;
                end
                default: begin
                    state   <= IDLE;
                    rdata   <= '0;
                    err     <= 1'b0;
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    typedef struct {bit d; logic [63:0] data; bit e;} exp_t;
    logic clk = 0, reset = 0;
    logic if_req = 0, dm_rd = 0, dm_wr = 0, mem_ready = 0, auto_rdy = 0;
    logic [63:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic [31:0] if_rdata;
    logic [63:0] dm_rdata, mem_addr, mem_wdata;
    logic if_done, dm_done, mem_req, mem_we, err, stall;
    exp_t sb[$];
    int total = 0, bad = 0;
    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .stall(stall)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return a == 64'h40 ? 64'h8B1F0001 : {a[31:0] ^ 32'h5A5A5A5A, ~a[31:0]};
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push(input bit d, input logic [63:0] data, input bit e);
        exp_t x;
        x.d = d; x.data = data; x.e = e;
        sb.push_back(x);
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    // zero-wait memory: ready in the first cycle mem_req is seen
    initial forever begin
        @(negedge clk);
        mem_ready = auto_rdy && mem_req;
        mem_rdata = (auto_rdy && mem_req) ? mem_val(mem_addr) : 64'h0;
    end
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset && (if_done || dm_done)) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_src", 64'(dm_done), 64'(e.d));
                if (e.d) chk("sb_dm_rdata", dm_rdata, e.data);
                else chk("sb_if_rdata", 64'(if_rdata), 64'(e.data[31:0]));
                chk("sb_err", 64'(err), 64'(e.e));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int cnt, nd, nd_after;
        bit seen_i, fin, prev, got;
        tick(); tick();
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_done", 64'({if_done, dm_done, err}), 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1;
        // fetch alone, zero-wait memory
        auto_rdy = 1;
        if_req = 1; if_addr = 64'h40;
        push(0, 64'h8B1F0001, 0);
        tick();
        chk("t1_mem_req", 64'(mem_req), 1);
        chk("t1_mem_we", 64'(mem_we), 0);
        chk("t1_mem_addr", mem_addr, 64'h40);
        chk("t1_stall", 64'(stall), 1);
        tick();
        chk("t1_if_done", 64'(if_done), 1);
        chk("t1_if_rdata", 64'(if_rdata), 64'h8B1F0001);
        chk("t1_stall_done", 64'(stall), 0);
        if_req = 0;
        tick();
        // data write and fetch in the same cycle: data first
        dm_wr = 1; dm_addr = 64'h100; dm_wdata = 64'hDEAD;
        if_req = 1; if_addr = 64'h80;
        push(1, mem_val(64'h100), 0);
        push(0, mem_val(64'h80), 0);
        tick();
        chk("t2_mem_we", 64'(mem_we), 1);
        chk("t2_mem_addr", mem_addr, 64'h100);
        chk("t2_mem_wdata", mem_wdata, 64'hDEAD);
        tick();
        chk("t2_dm_done", 64'(dm_done), 1);
        dm_wr = 0;
        tick();
        chk("t2_idle_gap", 64'(mem_req), 0);
        tick();
        chk("t2_if_gnt", 64'(mem_req), 1);
        chk("t2_if_addr", mem_addr, 64'h80);
        chk("t2_if_we", 64'(mem_we), 0);
        tick();
        chk("t2_if_done", 64'(if_done), 1);
        if_req = 0;
        tick();
        // starvation guard
        if_req = 1; if_addr = 64'h200;
        dm_rd = 1; dm_addr = 64'h300;
        for (int i = 0; i < 4; i++) push(1, mem_val(64'h300), 0);
        push(0, mem_val(64'h200), 0);
        push(1, mem_val(64'h300), 0);
        nd = 0; nd_after = 0; seen_i = 0; fin = 0; prev = 0;
        for (int c = 0; c < 80 && !fin; c++) begin
            tick();
            if (mem_req && !prev) begin
                if (mem_addr == 64'h300) begin
                    if (seen_i) nd_after++;
                    else nd++;
                end else seen_i = 1;
            end
            prev = mem_req;
            if (if_done) if_req = 0;
            if (dm_done && seen_i) begin
                dm_rd = 0;
                fin = 1;
            end
        end
        chk("t3_finished", 64'(fin), 1);
        chk("t3_dm_before_if", 64'(nd), 4);
        chk("t3_if_granted", 64'(seen_i), 1);
        chk("t3_dm_after_if", 64'(nd_after), 1);
        tick();
        // timeout
        auto_rdy = 0;
        dm_rd = 1; dm_addr = 64'h500;
        push(1, 64'h0, 1);
        cnt = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (dm_done) begin
                got = 1;
                chk("t4_err", 64'(err), 1);
                chk("t4_rdata", dm_rdata, 0);
                chk("t4_stall", 64'(stall), 0);
                dm_rd = 0;
            end else cnt += int'(mem_req);
        end
        chk("t4_done", 64'(got), 1);
        chk("t4_req_cycles", 64'(cnt), 16);
        tick();
        // async reset mid-access
        dm_rd = 1; dm_addr = 64'h600;
        tick(); tick();
        chk("t5_pre_req", 64'(mem_req), 1);
        #2 reset = 0;
        #1;
        chk("t5_req_cleared", 64'(mem_req), 0);
        chk("t5_addr_cleared", mem_addr, 0);
        chk("t5_stall_cleared", 64'(stall), 0);
        chk("t5_no_done", 64'({if_done, dm_done}), 0);
        dm_rd = 0;
        tick(); tick();
        chk("t5_no_done_held", 64'({if_done, dm_done}), 0);
        reset = 1;
        tick();
        chk("t5_idle", 64'(mem_req), 0);
        // read and write together: write wins, single done
        auto_rdy = 1;
        dm_rd = 1; dm_wr = 1; dm_addr = 64'h700; dm_wdata = 64'h1234;
        push(1, mem_val(64'h700), 0);
        tick();
        chk("t6_mem_we", 64'(mem_we), 1);
        chk("t6_mem_wdata", mem_wdata, 64'h1234);
        tick();
        chk("t6_dm_done", 64'(dm_done), 1);
        dm_rd = 0; dm_wr = 0;
        tick();
        chk("t6_single_done", 64'(dm_done), 0);
        chk("t6_idle", 64'(mem_req), 0);
        tick();
        chk("sb_drained", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
